// File: rtl/dm_src_sched_if.sv
`default_nettype none
// ============================================================================
// Module   : dm_src_sched_if
// Brief    : Producer handshakes and display-side outputs of dm_src_sched.
// Revision : 1.0 - initial release
// ============================================================================
interface dm_src_sched_if;
  logic        fib_valid;
  logic [15:0] fib_data;
  logic        fib_ack;
  logic        tmr_valid;
  logic [15:0] tmr_data;
  logic        tmr_ack;
  logic [15:0] data_2;
  logic [1:0]  modulo;
  logic        upd;
  logic        busy;

  modport master (
    output fib_valid, fib_data, tmr_valid, tmr_data,
    input  fib_ack, tmr_ack, data_2, modulo, upd, busy
  );

  modport slave (
    input  fib_valid, fib_data, tmr_valid, tmr_data,
    output fib_ack, tmr_ack, data_2, modulo, upd, busy
  );
endinterface
`default_nettype wire

// File: rtl/dm_src_sched.sv
`default_nettype none
// ============================================================================
// Module   : dm_src_sched
// Brief    : Arbitrates Fibonacci/Timer values onto the display and holds each
//            grant for HOLD_CNT cycles. Define DM_SCHED_TMR_PRIO_EN for fixed
//            Timer priority instead of round-robin tie-break.
// Revision : 1.0 - initial release
// ============================================================================
module dm_src_sched #(
  parameter int HOLD_CNT = 50
) (
  input  logic          clk,
  input  logic          rst,
  dm_src_sched_if.slave bus
);

  localparam int             CW         = $clog2(HOLD_CNT + 1);
  localparam logic [CW-1:0]  c_cnt_load = CW'(HOLD_CNT - 1);
  localparam logic [CW-1:0]  c_cnt_zero = '0;
  localparam logic [1:0]     c_src_none = 2'b00;
  localparam logic [1:0]     c_src_fib  = 2'b01;
  localparam logic [1:0]     c_src_tmr  = 2'b10;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic [15:0]   r_data_2;
  logic [15:0]   w_data_2_nxt;
  logic [1:0]    r_modulo;
  logic [1:0]    w_modulo_nxt;
  logic          r_fib_ack;
  logic          w_fib_ack_nxt;
  logic          r_tmr_ack;
  logic          w_tmr_ack_nxt;
  logic          r_upd;
  logic          w_upd_nxt;
  logic          w_req;
  logic          w_pick_tmr;

  assign w_req = bus.fib_valid | bus.tmr_valid;

`ifdef DM_SCHED_TMR_PRIO_EN
  assign w_pick_tmr = bus.tmr_valid;
`else
  // Remembers whether the previous grant went to Timer; resets to Timer so
  // Fibonacci wins the first tie.
  logic r_last_tmr;
  logic w_last_tmr_nxt;

  assign w_pick_tmr     = bus.tmr_valid & (~bus.fib_valid | ~r_last_tmr);
  assign w_last_tmr_nxt = ((r_state == ST_IDLE) && w_req) ? w_pick_tmr : r_last_tmr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_last_tmr <= 1'b1;
    end else begin
      r_last_tmr <= w_last_tmr_nxt;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= ST_IDLE;
      r_cnt     <= c_cnt_zero;
      r_data_2  <= 16'h0000;
      r_modulo  <= c_src_none;
      r_fib_ack <= 1'b0;
      r_tmr_ack <= 1'b0;
      r_upd     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_data_2  <= w_data_2_nxt;
      r_modulo  <= w_modulo_nxt;
      r_fib_ack <= w_fib_ack_nxt;
      r_tmr_ack <= w_tmr_ack_nxt;
      r_upd     <= w_upd_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_data_2_nxt  = r_data_2;
    w_modulo_nxt  = r_modulo;
    w_fib_ack_nxt = 1'b0;
    w_tmr_ack_nxt = 1'b0;
    w_upd_nxt     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_req) begin
          w_state_nxt = ST_HOLD;
          w_cnt_nxt   = c_cnt_load;
          w_upd_nxt   = 1'b1;
          if (w_pick_tmr) begin
            w_data_2_nxt  = bus.tmr_data;
            w_modulo_nxt  = c_src_tmr;
            w_tmr_ack_nxt = 1'b1;
          end else begin
            w_data_2_nxt  = bus.fib_data;
            w_modulo_nxt  = c_src_fib;
            w_fib_ack_nxt = 1'b1;
          end
        end
      end
      ST_HOLD: begin
        // Counter was loaded with HOLD_CNT-1, so HOLD lasts HOLD_CNT cycles.
        if (r_cnt == c_cnt_zero) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign bus.data_2  = r_data_2;
  assign bus.modulo  = r_modulo;
  assign bus.fib_ack = r_fib_ack;
  assign bus.tmr_ack = r_tmr_ack;
  assign bus.upd     = r_upd;
  assign bus.busy    = (r_state == ST_HOLD);

endmodule
`default_nettype wire

// File: tb/tb_dm_src_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_dm_src_sched
// Brief    : Scoreboard bench for dm_src_sched (HOLD_CNT=50 and HOLD_CNT=1).
// Revision : 1.0 - initial release
// ============================================================================
module tb_dm_src_sched;

  typedef struct {
    logic [15:0] data;
    logic [1:0]  mod;
    int          cyc;
  } exp_t;

  logic clk;
  logic rst;
  int   cyc;
  int   checks;
  int   errors;
  logic stop;
  exp_t q[$];
  exp_t q1[$];

  dm_src_sched_if b ();
  dm_src_sched_if b1 ();

  dm_src_sched #(.HOLD_CNT(50)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (b)
  );

  dm_src_sched #(.HOLD_CNT(1)) u_dut1 (
    .clk (clk),
    .rst (rst),
    .bus (b1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Scoreboard monitors: every upd pops one expected grant
  always @(negedge clk) begin
    exp_t e;
    if (b.upd) begin
      if (q.size() == 0) begin
        check("unexpected_upd", 32'(b.upd), 32'd0);
      end else begin
        e = q.pop_front();
        check("grant_data", 32'(b.data_2), 32'(e.data));
        check("grant_src", 32'(b.modulo), 32'(e.mod));
        check("grant_cycle", cyc, e.cyc);
        check("grant_ack", 32'({b.fib_ack, b.tmr_ack}), 32'({e.mod == 2'b01, e.mod == 2'b10}));
      end
    end else if (b.fib_ack || b.tmr_ack) begin
      check("ack_without_upd", 32'({b.fib_ack, b.tmr_ack}), 32'd0);
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (b1.upd) begin
      if (q1.size() == 0) begin
        check("unexpected_upd_h1", 32'(b1.upd), 32'd0);
      end else begin
        e = q1.pop_front();
        check("grant_data_h1", 32'(b1.data_2), 32'(e.data));
        check("grant_src_h1", 32'(b1.modulo), 32'(e.mod));
        check("grant_cycle_h1", cyc, e.cyc);
        check("grant_ack_h1", 32'({b1.fib_ack, b1.tmr_ack}), 32'({e.mod == 2'b01, e.mod == 2'b10}));
      end
    end else if (b1.fib_ack || b1.tmr_ack) begin
      check("ack_without_upd_h1", 32'({b1.fib_ack, b1.tmr_ack}), 32'd0);
    end
  end

  // Single offer from an idle DUT; returns at the negedge where ack is seen
  task automatic offer(input logic is_tmr, input logic [15:0] d);
    int   n;
    logic ack;
    exp_t e;
    e.data = d;
    e.mod  = is_tmr ? 2'b10 : 2'b01;
    e.cyc  = cyc + 1;
    q.push_back(e);
    if (is_tmr) begin
      b.tmr_valid = 1'b1;
      b.tmr_data  = d;
    end else begin
      b.fib_valid = 1'b1;
      b.fib_data  = d;
    end
    n = 0;
    do begin
      @(negedge clk);
      n++;
      ack = is_tmr ? b.tmr_ack : b.fib_ack;
    end while (!ack && n < 200);
    if (!ack) check("ack_timeout", 32'(ack), 32'd1);
    b.fib_valid = 1'b0;
    b.tmr_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (b.busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (b.busy) check("idle_timeout", 32'(b.busy), 32'd0);
  endtask

  task automatic producer(input logic is_tmr, input logic [15:0] d);
    logic ack;
    while (!stop) begin
      if (is_tmr) begin
        b.tmr_valid = 1'b1;
        b.tmr_data  = d;
      end else begin
        b.fib_valid = 1'b1;
        b.fib_data  = d;
      end
      do begin
        @(negedge clk);
        ack = is_tmr ? b.tmr_ack : b.fib_ack;
      end while (!ack && !stop);
      if (is_tmr) b.tmr_valid = 1'b0;
      else        b.fib_valid = 1'b0;
      @(negedge clk);
    end
  endtask

  initial begin
    int   nb;
    int   nt;
    int   nu;
    int   t0;
    exp_t e;
    checks = 0;
    errors = 0;
    stop   = 1'b0;
    rst    = 1'b0;
    b.fib_valid  = 1'b0;  b.fib_data  = 16'h0;
    b.tmr_valid  = 1'b0;  b.tmr_data  = 16'h0;
    b1.fib_valid = 1'b0;  b1.fib_data = 16'h0;
    b1.tmr_valid = 1'b0;  b1.tmr_data = 16'h0;
    repeat (3) @(negedge clk);

    check("rst_data_2", 32'(b.data_2), 32'h0);
    check("rst_modulo", 32'(b.modulo), 32'h0);
    check("rst_acks", 32'({b.fib_ack, b.tmr_ack}), 32'h0);
    check("rst_upd", 32'(b.upd), 32'h0);
    check("rst_busy", 32'(b.busy), 32'h0);
    check("rst_busy_h1", 32'(b1.busy), 32'h0);
    rst = 1'b1;
    @(negedge clk);

    // Fibonacci grant, 50-cycle hold, Timer pulse during HOLD is ignored
    offer(1'b0, 16'h0013);
    nb = 0;
    nt = 0;
    for (int i = 0; i < 60; i++) begin
      if (b.busy) nb++;
      if (b.tmr_ack) nt++;
      if (i == 20) begin
        b.tmr_valid = 1'b1;
        b.tmr_data  = 16'hBEEF;
      end
      if (i == 23) b.tmr_valid = 1'b0;
      @(negedge clk);
    end
    check("busy_len", nb, 50);
    check("pulse_tmr_ack", nt, 0);
    check("pulse_data_2", 32'(b.data_2), 32'h0013);
    check("pulse_modulo", 32'(b.modulo), 32'h1);

    // Timer grant followed by 200 quiet cycles
    offer(1'b1, 16'h0930);
    nu = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (b.upd) nu++;
    end
    check("quiet_upd", nu, 0);
    check("quiet_data_2", 32'(b.data_2), 32'h0930);
    check("quiet_modulo", 32'(b.modulo), 32'h2);

    // Asynchronous reset 10 cycles into HOLD
    offer(1'b0, 16'h4444);
    repeat (10) @(negedge clk);
    check("hold_busy", 32'(b.busy), 32'h1);
    #2 rst = 1'b0;
    #1;
    check("arst_data_2", 32'(b.data_2), 32'h0);
    check("arst_modulo", 32'(b.modulo), 32'h0);
    check("arst_busy", 32'(b.busy), 32'h0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Both sources contending from reset
    t0 = cyc;
    for (int i = 0; i < 3; i++) begin
`ifdef DM_SCHED_TMR_PRIO_EN
      e.data = 16'h2222;
      e.mod  = 2'b10;
`else
      e.data = (i == 1) ? 16'h2222 : 16'h1111;
      e.mod  = (i == 1) ? 2'b10 : 2'b01;
`endif
      e.cyc  = t0 + 1 + 51 * i;
      q.push_back(e);
    end
    fork
      producer(1'b0, 16'h1111);
      producer(1'b1, 16'h2222);
      begin
        repeat (104) @(negedge clk);
        stop = 1'b1;
      end
    join
    b.fib_valid = 1'b0;
    b.tmr_valid = 1'b0;
    wait_idle();
    repeat (5) @(negedge clk);

    // HOLD_CNT=1 instance with Fibonacci valid held high
    t0 = cyc;
    for (int i = 0; i < 5; i++) begin
      e.data = 16'h5555;
      e.mod  = 2'b01;
      e.cyc  = t0 + 1 + 2 * i;
      q1.push_back(e);
    end
    b1.fib_valid = 1'b1;
    b1.fib_data  = 16'h5555;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      check("h1_busy", 32'(b1.busy), 32'(i % 2));
    end
    b1.fib_valid = 1'b0;
    repeat (4) @(negedge clk);

    check("q_drained", q.size(), 0);
    check("q1_drained", q1.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
